alu_control_muldiv: RTL and testbench
=====================================

// Module: alu_control_muldiv
// PURPOSE
//  Next-generation ALU control for the MIPS datapath. Decodes aluop/functioncode into the
//  4-bit ALU operation and adds a multi-cycle multiply/divide sequencer with HI/LO registers.
//  Sits between main control and the ALU. Drives stall to the PC/pipeline registers while
//  a mult/div is in flight.
// PARAMETERS
//  WIDTH   32  operand width; also the number of iteration cycles for mult/div
//  CNT_W   6   iteration counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk           in   1        single clock; all state updates on rising edge
//  reset         in   1        synchronous, active-high
//  aluop         in   2        00 add (lw/sw), 01 sub (beq), 10 R-type (use functioncode), 11 add
//  functioncode  in   6        R-type funct field
//  start         in   1        instruction valid this cycle; qualifies mult/div launch
//  a             in   WIDTH    rs operand
//  b             in   WIDTH    rt operand
//  aluoperation  out  4        ALU op code, combinational
//  hilo_out      out  WIDTH    mfhi -> hi, mflo -> lo, otherwise 0; combinational
//  busy          out  1        sequencer in BUSY
//  done          out  1        one-cycle pulse: hi/lo hold new result
//  stall         out  1        busy & start & (funct is mult/div/mfhi/mflo, aluop==10)
// BEHAVIOUR
//  Decode (aluop==10): 000000 sll 1111 | 000010 srl 1110 | 100000 add 0010 | 100010 sub 0110
//   100100 and 0000 | 100101 or 0001 | 100110 xor 1101 | 100111 nor 1100 | 101010 slt 0111.
//   Any other funct, including mult/div/mfhi/mflo -> add 0010. aluop 00/11 -> 0010, 01 -> 0110.
//  Mult/div funct: 011000 mult, 011001 multu, 011010 div, 011011 divu; mfhi 010000, mflo 010010.
//  FSM states IDLE, BUSY, DONE. Reset -> IDLE, hi=lo=0, count=0, busy=0, done=0.
//  Launch: start & aluop==10 & mult/div funct & state in {IDLE,DONE} at edge E0.
//   Operands are latched; signed ops convert to magnitudes and record result signs.
//   Next state BUSY, count=0.
//  BUSY: one radix-2 step per edge (shift-add mult, restoring div). count increments.
//   At the WIDTH-th BUSY edge: signs are applied, hi/lo are written, next state DONE.
//  Latency: done is high in the cycle WIDTH+1 cycles after the launch cycle. hi/lo change only
//   on that edge.
//  DONE: done=1 for exactly one cycle. Next state BUSY on a new launch, else IDLE
//   (back-to-back ops allowed).
//  Results: mult/multu {hi,lo} = full 2*WIDTH product. div/divu lo = quotient, hi = remainder.
//   Signed div truncates toward zero; remainder takes the dividend's sign.
//   Most-negative / -1 -> lo = most-negative, hi = 0.
//  Divide by zero (b==0): no iteration. Edge E0 goes directly to DONE with hi = a, lo = all ones.
//  Launch attempt while in BUSY is ignored; stall=1 holds the instruction until DONE.
//  mfhi/mflo while in BUSY: stall=1. In DONE, hilo_out already returns the new value.
//  Reset mid-BUSY aborts: IDLE, hi=lo=0, no done pulse.
//  busy = (state==BUSY). stall is combinational and never asserted in IDLE or DONE.
// TESTING
//  1 aluop=10, each of the 9 ALU functs, plus aluop 00/01/11 -> table codes exactly.
//    funct=011000 -> 0010.
//  2 WIDTH=32, mult a=-3 b=7, start 1 cycle -> busy 32 cycles, done at cycle 33,
//    {hi,lo}=FFFFFFFF_FFFFFFEB. multu same operands -> hi=00000006, lo=FFFFFFEB.
//  3 div a=-7 b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. divu a=7 b=0 -> done next cycle,
//    hi=00000007, lo=FFFFFFFF.
//  4 mflo with start=1 during BUSY -> stall=1 every cycle until DONE.
//    In DONE, stall=0 and hilo_out=new lo.
//  5 mult launched in DONE cycle of prior div -> no IDLE gap, second done 33 cycles later.
//  6 reset asserted at BUSY cycle 10 -> next cycle IDLE, hi=lo=0, done never pulses.
//    Repeat 2-3 with WIDTH=8.

Source files
------------

// File: rtl/alu_control_muldiv.sv
// ALU control decode plus a multi-cycle radix-2 multiply/divide sequencer with HI/LO registers.
// Stalls the pipeline while a mult/div is in flight and an instruction needs the sequencer.
module alu_control_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       aluop,
    input  logic [5:0]       functioncode,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       aluoperation,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   operand;
    logic [CNT_W-1:0]   count;
    logic               op_div;
    logic               neg_res;
    logic               neg_rem;

    logic               is_rtype;
    logic               is_muldiv;
    logic               is_move;
    logic               launch;
    logic               div_by_zero;
    logic               last_step;
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        aluoperation = 4'b0010;
        case (aluop)
            2'b01: aluoperation = 4'b0110;
            2'b10: begin
                case (functioncode)
                    F_SLL:   aluoperation = 4'b1111;
                    F_SRL:   aluoperation = 4'b1110;
                    F_ADD:   aluoperation = 4'b0010;
                    F_SUB:   aluoperation = 4'b0110;
                    F_AND:   aluoperation = 4'b0000;
                    F_OR:    aluoperation = 4'b0001;
                    F_XOR:   aluoperation = 4'b1101;
                    F_NOR:   aluoperation = 4'b1100;
                    F_SLT:   aluoperation = 4'b0111;
                    default: aluoperation = 4'b0010;
                endcase
            end
            default: aluoperation = 4'b0010;
        endcase
    end

    // mult/multu/div/divu share the 0110xx funct prefix; bit 1 selects divide, bit 0 unsigned
    assign is_rtype    = (aluop == 2'b10);
    assign is_muldiv   = is_rtype && (functioncode[5:2] == 4'b0110);
    assign is_move     = is_rtype && ((functioncode == F_MFHI) || (functioncode == F_MFLO));
    assign launch      = start && is_muldiv && (state != BUSY);
    assign div_by_zero = functioncode[1] && (b == '0);
    assign last_step   = (count == CNT_W'(WIDTH - 1));

    assign busy  = (state == BUSY);
    assign done  = (state == DONE);
    assign stall = busy && start && (is_muldiv || is_move);

    always_comb begin
        hilo_out = '0;
        if (is_rtype && functioncode == F_MFHI) begin
            hilo_out = hi;
        end else if (is_rtype && functioncode == F_MFLO) begin
            hilo_out = lo;
        end
    end

    assign signed_op = ~functioncode[0];
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // Multiply: acc_hi:acc_lo is the shifting product, acc_lo starts as the multiplier.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign mult_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    assign div_shift   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_trial   = div_shift - {1'b0, operand};
    assign div_ok      = ~div_trial[WIDTH];
    assign prod        = {mult_sum, acc_lo[WIDTH-1:1]};
    assign prod_signed = neg_res ? -prod : prod;
    assign quot        = {acc_lo[WIDTH-2:0], div_ok};
    assign rem         = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_next = div_by_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (launch) begin
                    state_next = div_by_zero ? DONE : BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // hi/lo are written only on the final iteration edge or directly on a divide-by-zero launch
    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
            count   <= '0;
            op_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (launch) begin
            op_div  <= functioncode[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            count   <= '0;
            acc_hi  <= '0;
            acc_lo  <= functioncode[1] ? a_mag : b_mag;
            operand <= functioncode[1] ? b_mag : a_mag;
            if (div_by_zero) begin
                hi <= a;
                lo <= '1;
            end
        end else if (state == BUSY) begin
            count <= count + CNT_W'(1);
            if (op_div) begin
                acc_hi <= rem;
                acc_lo <= quot;
            end else begin
                acc_hi <= mult_sum[WIDTH:1];
                acc_lo <= {mult_sum[0], acc_lo[WIDTH-1:1]};
            end
            if (last_step) begin
                if (op_div) begin
                    lo <= neg_res ? -quot : quot;
                    hi <= neg_rem ? -rem : rem;
                end else begin
                    hi <= prod_signed[2*WIDTH-1:WIDTH];
                    lo <= prod_signed[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Scoreboard bench for alu_control_muldiv: a 32-bit and an 8-bit instance share stimulus,
// and a negedge monitor checks the selected one against an arithmetic reference model.
module tb_alu_control_muldiv;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  aluop;
    logic [5:0]  functioncode;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;

    logic [3:0]  op32, op8;
    logic [31:0] hl32;
    logic [7:0]  hl8;
    logic        busy32, busy8, done32, done8, stall32, stall8;

    logic        sel = 1'b0;
    int          w = 32;
    logic [3:0]  dut_op;
    logic [31:0] dut_hl;
    logic        dut_busy, dut_done, dut_stall;

    typedef struct {
        int          launch_cyc;
        int          done_cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        scoreboard[$];
    exp_t        mon_exp;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_seen = 0;
    int          last_launch = 0;
    int          last_done = 0;
    logic        mon_on = 1'b0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic        exp_busy, exp_stall;
    logic [31:0] exp_hl;
    logic [3:0]  exp_op;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_control_muldiv #(.WIDTH(32), .CNT_W(6)) u_dut32 (
        .clk(clk), .reset(reset), .aluop(aluop), .functioncode(functioncode),
        .start(start), .a(a), .b(b), .aluoperation(op32), .hilo_out(hl32),
        .busy(busy32), .done(done32), .stall(stall32)
    );

    alu_control_muldiv #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .reset(reset), .aluop(aluop), .functioncode(functioncode),
        .start(start), .a(a[7:0]), .b(b[7:0]), .aluoperation(op8), .hilo_out(hl8),
        .busy(busy8), .done(done8), .stall(stall8)
    );

    assign dut_op    = sel ? op8 : op32;
    assign dut_hl    = sel ? {24'd0, hl8} : hl32;
    assign dut_busy  = sel ? busy8 : busy32;
    assign dut_done  = sel ? done8 : done32;
    assign dut_stall = sel ? stall8 : stall32;

    function automatic logic [3:0] ref_aluop(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b01) return 4'b0110;
        if (op != 2'b10) return 4'b0010;
        case (fn)
            F_SLL:   return 4'b1111;
            F_SRL:   return 4'b1110;
            F_SUB:   return 4'b0110;
            F_AND:   return 4'b0000;
            F_OR:    return 4'b0001;
            F_XOR:   return 4'b1101;
            F_NOR:   return 4'b1100;
            F_SLT:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    // Plain arithmetic on wd-bit values: signed via sign extension, division truncates toward zero
    task automatic ref_muldiv(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv,
                              input int wd, output logic [31:0] rhi, output logic [31:0] rlo);
        logic [63:0] m, ua, ub, up;
        longint      sa, sbv, sq, sr;
        m  = (64'd1 << wd) - 64'd1;
        ua = {32'd0, av} & m;
        ub = {32'd0, bv} & m;
        sa = longint'(ua);
        if (ua[wd-1]) sa = sa - (longint'(1) << wd);
        sbv = longint'(ub);
        if (ub[wd-1]) sbv = sbv - (longint'(1) << wd);
        rhi = '0;
        rlo = '0;
        if (fn == F_MULT || fn == F_MULTU) begin
            up  = (fn == F_MULT) ? 64'(sa * sbv) : ua * ub;
            rlo = 32'(up & m);
            rhi = 32'((up >> wd) & m);
        end else if (ub == 64'd0) begin
            rhi = 32'(ua);
            rlo = 32'(m);
        end else if (fn == F_DIV) begin
            sq  = sa / sbv;
            sr  = sa % sbv;
            rlo = 32'(64'(sq) & m);
            rhi = 32'(64'(sr) & m);
        end else begin
            rlo = 32'((ua / ub) & m);
            rhi = 32'((ua % ub) & m);
        end
    endtask

    // Monitor: retire scoreboard entries on done, then check per-cycle outputs
    always @(negedge clk) begin
        if (mon_on) begin
            if (dut_done || (scoreboard.size() > 0 && scoreboard[0].done_cyc == cyc)) begin
                checks++;
                if (scoreboard.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL done_unexpected cyc=%0d got done=%b expected done=0", cyc, dut_done);
                end else begin
                    mon_exp = scoreboard.pop_front();
                    done_seen++;
                    if (!dut_done || mon_exp.done_cyc != cyc) begin
                        failures++;
                        $display("[TB] FAIL done_timing cyc=%0d got done=%b expected done=1 at cyc=%0d",
                                 cyc, dut_done, mon_exp.done_cyc);
                    end
                    model_hi = mon_exp.hi;
                    model_lo = mon_exp.lo;
                end
            end

            exp_busy = (scoreboard.size() > 0) && (scoreboard[0].launch_cyc < cyc)
                       && (cyc < scoreboard[0].done_cyc);
            checks++;
            if (dut_busy !== exp_busy) begin
                failures++;
                $display("[TB] FAIL busy cyc=%0d got=%b expected=%b", cyc, dut_busy, exp_busy);
            end

            exp_stall = exp_busy && start && (aluop == 2'b10) &&
                        (functioncode inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO});
            checks++;
            if (dut_stall !== exp_stall) begin
                failures++;
                $display("[TB] FAIL stall cyc=%0d got=%b expected=%b", cyc, dut_stall, exp_stall);
            end

            exp_hl = '0;
            if (aluop == 2'b10 && functioncode == F_MFHI) exp_hl = model_hi;
            if (aluop == 2'b10 && functioncode == F_MFLO) exp_hl = model_lo;
            checks++;
            if (dut_hl !== exp_hl) begin
                failures++;
                $display("[TB] FAIL hilo_out cyc=%0d funct=%b got=%h expected=%h", cyc, functioncode, dut_hl, exp_hl);
            end

            exp_op = ref_aluop(aluop, functioncode);
            checks++;
            if (dut_op !== exp_op) begin
                failures++;
                $display("[TB] FAIL aluoperation aluop=%b funct=%b got=%b expected=%b",
                         aluop, functioncode, dut_op, exp_op);
            end

            if (reset) begin
                scoreboard.delete();
                model_hi = '0;
                model_lo = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] av, input logic [31:0] bv);
        start        = st;
        aluop        = op;
        functioncode = fn;
        a            = av;
        b            = bv;
        step();
    endtask

    task automatic idle();
        drive(1'b0, 2'b10, F_ADD, $urandom, $urandom);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) idle();
        reset = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv);
        exp_t        e;
        logic [31:0] m;
        logic        dz;
        m  = 32'((64'd1 << w) - 64'd1);
        dz = (fn == F_DIV || fn == F_DIVU) && ((bv & m) == 32'd0);
        ref_muldiv(fn, av, bv, w, e.hi, e.lo);
        e.launch_cyc = cyc;
        e.done_cyc   = dz ? cyc + 1 : cyc + w + 1;
        last_launch  = e.launch_cyc;
        last_done    = e.done_cyc;
        scoreboard.push_back(e);
        drive(1'b1, 2'b10, fn, av, bv);
    endtask

    task automatic wait_done(input logic [5:0] fn, input logic st);
        int target;
        target = done_seen + 1;
        for (int i = 0; i < w + 4 && done_seen < target; i++) begin
            drive(st, 2'b10, fn, $urandom, $urandom);
        end
        if (done_seen < target) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout cyc=%0d got no done expected done within %0d cycles", cyc, w + 4);
        end
    endtask

    task automatic read_hilo();
        drive(1'b0, 2'b10, F_MFHI, $urandom, $urandom);
        drive(1'b0, 2'b10, F_MFLO, $urandom, $urandom);
    endtask

    task automatic run_op(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv);
        apply_stimulus(fn, av, bv);
        wait_done(F_ADD, 1'b0);
        read_hilo();
    endtask

    task automatic rand_operands(output logic [31:0] av, output logic [31:0] bv);
        int mode;
        mode = $urandom_range(5);
        av   = $urandom;
        bv   = $urandom;
        case (mode)
            0: bv = 32'd0;
            1: begin av = 32'(64'd1 << (w - 1)); bv = 32'hFFFF_FFFF; end
            2: begin av = $urandom_range(20) - 10; bv = $urandom_range(6) - 3; end
            default: ;
        endcase
    endtask

    task automatic run_phase(input logic s);
        logic [5:0]  fns[10];
        logic [5:0]  ops[4];
        logic [31:0] ra, rb;
        int          k;
        sel = s;
        w   = s ? 8 : 32;
        do_reset(2);
        read_hilo();

        fns = '{F_SLL, F_SRL, F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_MULT};
        foreach (fns[i]) drive(1'b0, 2'b10, fns[i], $urandom, $urandom);
        for (int i = 0; i < 6; i++) drive(1'b0, 2'b10, 6'($urandom), $urandom, $urandom);
        drive(1'b1, 2'b00, 6'($urandom), $urandom, $urandom);
        drive(1'b1, 2'b01, 6'($urandom), $urandom, $urandom);
        drive(1'b1, 2'b11, F_MULT, $urandom, $urandom);

        run_op(F_MULT, -32'sd3, 32'd7);
        run_op(F_MULTU, -32'sd3, 32'd7);
        run_op(F_DIV, -32'sd7, 32'd2);
        run_op(F_DIVU, 32'd7, 32'd0);
        run_op(F_DIV, 32'(64'd1 << (w - 1)), 32'hFFFF_FFFF);
        run_op(F_DIV, $urandom, 32'd0);

        // Launch attempts and mflo while busy must stall without disturbing the running op
        apply_stimulus(F_MULT, $urandom, $urandom);
        drive(1'b1, 2'b10, F_MULT, $urandom, $urandom);
        drive(1'b1, 2'b10, F_DIVU, $urandom, $urandom);
        wait_done(F_MFLO, 1'b1);
        read_hilo();

        // Back-to-back: mult launched in the DONE cycle of a divide
        apply_stimulus(F_DIV, $urandom, $urandom | 32'd1);
        while (cyc < last_done) idle();
        apply_stimulus(F_MULT, $urandom, $urandom);
        wait_done(F_ADD, 1'b0);
        read_hilo();

        // Reset in the middle of an operation aborts it with no done pulse
        k = (w > 10) ? 10 : w / 2;
        apply_stimulus(F_MULTU, $urandom | 32'd1, $urandom | 32'd1);
        while (cyc < last_launch + k) idle();
        do_reset(1);
        repeat (w + 4) idle();
        read_hilo();

        ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        for (int i = 0; i < 24; i++) begin
            rand_operands(ra, rb);
            apply_stimulus(ops[$urandom_range(3)], ra, rb);
            while (cyc < last_done) idle();
            if ($urandom_range(2) != 0) begin
                read_hilo();
            end
        end
        repeat (3) idle();
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        aluop        = 2'b00;
        functioncode = F_ADD;
        a            = '0;
        b            = '0;
        step();
        mon_on = 1'b1;
        run_phase(1'b0);
        run_phase(1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog cyc=%0d got no completion expected finish before time limit", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
